spi_master: RTL and testbench
=============================

SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning the bit width of the command, address and data fields.
REQ-002 SHALL have parameter CLK_DIV, default 4, meaning i_clk cycles per SCK half-period (legal range 2..255).
REQ-003 SHALL have port i_clk, input, 1 bit: the single system clock, rising-edge only.
REQ-004 SHALL have port i_rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port i_start, input, 1 bit: transaction request, sampled only in IDLE.
REQ-006 SHALL have port i_rw, input, 1 bit: 0 = write (CMD 8'h02), 1 = read (CMD 8'h03).
REQ-007 SHALL have port i_addr, input, DATA_WIDTH bits: start address.
REQ-008 SHALL have port i_len, input, 8 bits: number of data bytes; 0 is treated as 1.
REQ-009 SHALL have port i_wdata, input, DATA_WIDTH bits: write byte source.
REQ-010 SHALL have port o_wdata_req, output, 1 bit: one-cycle pulse when i_wdata is loaded into the shifter.
REQ-011 SHALL have port o_rdata, output, DATA_WIDTH bits: last received read byte.
REQ-012 SHALL have port o_rdata_valid, output, 1 bit: one-cycle pulse when o_rdata is updated.
REQ-013 SHALL have port o_busy, output, 1 bit: high in every state except IDLE.
REQ-014 SHALL have port o_done, output, 1 bit: one-cycle pulse at transaction end.
REQ-015 SHALL have ports o_spi_sck, o_spi_mosi and o_spi_cs as 1-bit outputs, and i_spi_miso as a 1-bit input.

Function
REQ-016 SHALL implement states IDLE -> CMD -> ADDR -> DATA -> TAIL -> IDLE, with each of CMD, ADDR and DATA-byte spanning DATA_WIDTH SCK periods.
REQ-017 SHALL, when i_start=1 in IDLE, latch i_rw, i_addr, i_len and i_wdata, and drive o_spi_cs low on the next cycle (t0).
REQ-018 SHALL use SPI mode 0: SCK idles 0, MSB first, MOSI changes only at t0 or on SCK falling edges, and MISO is sampled on SCK rising edges.
REQ-019 SHALL place bit k (k = 0..B-1, B = DATA_WIDTH*(2+len)) with its rising edge at t0+(2k+1)*CLK_DIV and its falling edge at t0+(2k+2)*CLK_DIV.
REQ-020 SHALL, in TAIL, hold SCK low for CLK_DIV cycles, then drive o_spi_cs high and pulse o_done in the same cycle: t0+(2B+1)*CLK_DIV.
REQ-021 SHALL, on writes, use the i_wdata latched at start for byte 0, and pulse o_wdata_req at t0 and at each later data-byte load (the last falling edge of the previous byte).
REQ-022 SHALL require the user to present the next write byte within one byte time of an o_wdata_req pulse.
REQ-023 SHALL, on reads, shift in MISO during the data phase and, one cycle after the rising edge of the final bit of each byte, update o_rdata and pulse o_rdata_valid.
REQ-024 SHALL ignore MISO during CMD, ADDR and write transactions.
REQ-025 SHALL drive o_spi_mosi to 0 in IDLE and during read data bytes.
REQ-026 SHALL use a byte counter wide enough for 256 (len 0..255, with 0 mapped to 1), with no wrap-around.
REQ-027 SHALL ignore i_start while o_busy=1, including the o_done cycle; a new start is accepted no earlier than the cycle after o_done, giving a minimum CS-high time of 2 cycles.
REQ-028 SHALL ignore changes to i_rw, i_addr and i_len after they are latched.

Reset
REQ-029 SHALL, on i_rst=0 (asynchronous), force o_spi_cs=1, o_spi_sck=0, o_spi_mosi=0, o_busy=0, o_done=0, o_wdata_req=0, o_rdata_valid=0, o_rdata=0 and state=IDLE, including mid-transaction.
REQ-030 SHALL, on release of reset, be able to accept i_start on the first rising edge of i_clk.

Verification
REQ-031 SHALL cover a write: CLK_DIV=2, i_rw=0, addr=8'hFD, len=3, wdata 8'h99/8'h9A/8'h9B supplied on o_wdata_req -> MOSI bits 02 FD 99 9A 9B, 40 SCK rising edges, CS low for 162 cycles, single o_done pulse.
REQ-032 SHALL cover a read: i_rw=1, addr=8'h00, len=2, with a slave model returning 8'hAA then 8'h55 -> MOSI bits 03 00 00 00, o_rdata_valid pulses twice with 8'hAA then 8'h55.
REQ-033 SHALL cover len=0: the transaction carries exactly 1 data byte, B=24, and CS is low for 49*CLK_DIV cycles.
REQ-034 SHALL cover i_start pulsed while busy and in the o_done cycle -> both ignored, and the next start is accepted the cycle after o_done.
REQ-035 SHALL cover assertion of i_rst=0 during ADDR bit 3 -> CS=1, SCK=0, MOSI=0 and busy=0 immediately; no o_done; a following write completes correctly.
REQ-036 SHALL cover timing checks: MOSI stable on every SCK rising edge, and the SCK half-period equal to CLK_DIV cycles for CLK_DIV=2 and CLK_DIV=5.

Source files
------------

// File: rtl/spi_master.sv
// SPI mode-0 master: CS low, then CMD, ADDR and a burst of data bytes, MSB first.
// SCK runs at CLK_DIV system cycles per half-period; a TAIL half-period precedes CS release.
module spi_master #(
  parameter int DATA_WIDTH = 8,
  parameter int CLK_DIV    = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic                  i_rw,
  input  logic [DATA_WIDTH-1:0] i_addr,
  input  logic [7:0]            i_len,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic                  o_wdata_req,
  output logic [DATA_WIDTH-1:0] o_rdata,
  output logic                  o_rdata_valid,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_spi_sck,
  output logic                  o_spi_mosi,
  output logic                  o_spi_cs,
  input  logic                  i_spi_miso
);
  localparam int BCW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [7:0]            DIV_LAST  = 8'(CLK_DIV - 1);
  localparam logic [BCW-1:0]        BIT_LAST  = BCW'(DATA_WIDTH - 1);
  localparam logic [DATA_WIDTH-1:0] CMD_WRITE = DATA_WIDTH'(8'h02);
  localparam logic [DATA_WIDTH-1:0] CMD_READ  = DATA_WIDTH'(8'h03);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, TAIL} state_t;

  state_t                state, next_state;
  logic [7:0]            div_cnt;
  logic [BCW-1:0]        bit_cnt;
  logic [8:0]            rem_cnt;
  logic [DATA_WIDTH-1:0] tx_sr, rx_sr, addr_lat, wdata_lat;
  logic                  rw_lat;
  logic                  div_end, fall_tick, field_end, start_ok;

  assign div_end   = (div_cnt == DIV_LAST);
  assign fall_tick = o_spi_sck && div_end;
  assign field_end = fall_tick && (bit_cnt == BIT_LAST);
  // o_done shares its cycle with IDLE, so a start there must still be refused.
  assign start_ok  = i_start && !o_done;

  assign o_busy     = (state != IDLE);
  assign o_spi_mosi = tx_sr[DATA_WIDTH-1];

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (start_ok) next_state = CMD;
      CMD:  if (field_end) next_state = ADDR;
      ADDR: if (field_end) next_state = DATA;
      DATA: if (field_end && rem_cnt == 9'd1) next_state = TAIL;
      TAIL: if (div_end) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      div_cnt       <= '0;
      bit_cnt       <= '0;
      rem_cnt       <= '0;
      tx_sr         <= '0;
      rx_sr         <= '0;
      addr_lat      <= '0;
      wdata_lat     <= '0;
      rw_lat        <= 1'b0;
      o_spi_sck     <= 1'b0;
      o_spi_cs      <= 1'b1;
      o_done        <= 1'b0;
      o_wdata_req   <= 1'b0;
      o_rdata_valid <= 1'b0;
      o_rdata       <= '0;
    end else begin
      o_done        <= 1'b0;
      o_wdata_req   <= 1'b0;
      o_rdata_valid <= 1'b0;
      case (state)
        IDLE: begin
          div_cnt   <= '0;
          o_spi_sck <= 1'b0;
          if (start_ok) begin
            rw_lat      <= i_rw;
            addr_lat    <= i_addr;
            wdata_lat   <= i_wdata;
            rem_cnt     <= (i_len == 8'd0) ? 9'd1 : {1'b0, i_len};
            tx_sr       <= i_rw ? CMD_READ : CMD_WRITE;
            bit_cnt     <= '0;
            o_spi_cs    <= 1'b0;
            o_wdata_req <= !i_rw;
          end
        end
        TAIL: begin
          div_cnt <= div_cnt + 8'd1;
          if (div_end) begin
            div_cnt  <= '0;
            o_spi_cs <= 1'b1;
            o_done   <= 1'b1;
          end
        end
        default: begin
          div_cnt <= div_end ? '0 : div_cnt + 8'd1;
          if (div_end) o_spi_sck <= !o_spi_sck;
          // MISO is taken one cycle into SCK high, so o_rdata lands one cycle after the rise.
          if (state == DATA && rw_lat && o_spi_sck && div_cnt == '0) begin
            rx_sr <= {rx_sr[DATA_WIDTH-2:0], i_spi_miso};
            if (bit_cnt == BIT_LAST) begin
              o_rdata       <= {rx_sr[DATA_WIDTH-2:0], i_spi_miso};
              o_rdata_valid <= 1'b1;
            end
          end
          if (fall_tick) begin
            if (bit_cnt != BIT_LAST) begin
              bit_cnt <= bit_cnt + BCW'(1);
              tx_sr   <= tx_sr << 1;
            end else begin
              bit_cnt <= '0;
              case (state)
                CMD:  tx_sr <= addr_lat;
                ADDR: tx_sr <= rw_lat ? '0 : wdata_lat;
                default: begin
                  if (rem_cnt != 9'd1) begin
                    tx_sr       <= rw_lat ? '0 : i_wdata;
                    o_wdata_req <= !rw_lat;
                  end else begin
                    tx_sr <= '0;
                  end
                  rem_cnt <= rem_cnt - 9'd1;
                end
              endcase
            end
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: randomized transactions checked against a bit-level model of the SPI frame.
module tb_spi_master;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, start, rw, miso, sel;
  logic [7:0] addr, len, wdata;

  logic       a_req, a_rv, a_busy, a_done, a_sck, a_mosi, a_cs;
  logic       b_req, b_rv, b_busy, b_done, b_sck, b_mosi, b_cs;
  logic [7:0] a_rdata, b_rdata;
  logic       start_a, start_b;

  assign start_a = start && !sel;
  assign start_b = start && sel;

  spi_master #(.DATA_WIDTH(8), .CLK_DIV(2)) u_dut_a (
    .i_clk(clk), .i_rst(rst_n), .i_start(start_a), .i_rw(rw), .i_addr(addr), .i_len(len),
    .i_wdata(wdata), .o_wdata_req(a_req), .o_rdata(a_rdata), .o_rdata_valid(a_rv),
    .o_busy(a_busy), .o_done(a_done), .o_spi_sck(a_sck), .o_spi_mosi(a_mosi),
    .o_spi_cs(a_cs), .i_spi_miso(miso));

  spi_master #(.DATA_WIDTH(8), .CLK_DIV(5)) u_dut_b (
    .i_clk(clk), .i_rst(rst_n), .i_start(start_b), .i_rw(rw), .i_addr(addr), .i_len(len),
    .i_wdata(wdata), .o_wdata_req(b_req), .o_rdata(b_rdata), .o_rdata_valid(b_rv),
    .o_busy(b_busy), .o_done(b_done), .o_spi_sck(b_sck), .o_spi_mosi(b_mosi),
    .o_spi_cs(b_cs), .i_spi_miso(miso));

  logic       m_req, m_rv, m_busy, m_done, m_sck, m_mosi, m_cs;
  logic [7:0] m_rdata;
  assign m_req   = sel ? b_req   : a_req;
  assign m_rv    = sel ? b_rv    : a_rv;
  assign m_busy  = sel ? b_busy  : a_busy;
  assign m_done  = sel ? b_done  : a_done;
  assign m_sck   = sel ? b_sck   : a_sck;
  assign m_mosi  = sel ? b_mosi  : a_mosi;
  assign m_cs    = sel ? b_cs    : a_cs;
  assign m_rdata = sel ? b_rdata : a_rdata;

  int errors, checks;
  logic [7:0] wq[$];
  logic [7:0] rq[$];

  // observations of the last transaction
  int n_rise, cs_low, n_done, done_cyc, n_req, mosi_err, first_bad, edge_err;
  int rd_cnt, rd_err, glitch;
  logic cs_t0, cs_after;
  bit timeout;

  task automatic run_txn(input int d, input logic rwv, input logic [7:0] av,
                         input logic [7:0] lv, input bit poke);
    int neff = (lv == 8'd0) ? 1 : int'(lv);
    int nb = 8 * (2 + neff);
    int done_exp = (2 * nb + 1) * d;
    bit eb[$];
    bit sb[$];
    logic [7:0] by[$];
    logic [7:0] cur;
    int c, falls, wi;
    logic psck, pmosi;
    by = {};
    eb = {};
    sb = {};
    by.push_back(rwv ? 8'h03 : 8'h02);
    by.push_back(av);
    for (int j = 0; j < neff; j++) by.push_back(rwv ? 8'h00 : wq[j]);
    for (int i = 0; i < by.size(); i++) begin
      cur = by[i];
      for (int b = 7; b >= 0; b--) eb.push_back(cur[b]);
    end
    for (int k = 0; k < nb; k++) begin
      if (rwv && k >= 16) begin
        cur = rq[(k - 16) / 8];
        sb.push_back(cur[7 - ((k - 16) % 8)]);
      end else begin
        sb.push_back(1'($urandom));
      end
    end
    n_rise = 0; cs_low = 0; n_done = 0; done_cyc = -1; n_req = 0; mosi_err = 0;
    first_bad = -1; edge_err = 0; rd_cnt = 0; rd_err = 0; glitch = 0; timeout = 0;
    cs_t0 = 1'bx; cs_after = 1'bx;
    start = 1'b1; rw = rwv; addr = av; len = lv;
    wdata = (wq.size() > 0) ? wq[0] : 8'h00;
    wi = 1; miso = sb[0]; falls = 0; c = 0; psck = 1'b0; pmosi = 1'b0;
    @(negedge clk);
    start = 1'b0; rw = 1'($urandom); addr = 8'($urandom); len = 8'($urandom);
    while (1) begin
      if (c == 0) cs_t0 = m_cs;
      if (!m_cs) cs_low++;
      if (m_sck && !psck) begin
        if (n_rise < nb && m_mosi !== eb[n_rise]) begin
          mosi_err++;
          if (first_bad < 0) first_bad = n_rise;
        end
        if (c != (2 * n_rise + 1) * d) edge_err++;
        n_rise++;
      end
      if (!m_sck && psck) begin
        falls++;
        if (c != 2 * falls * d) edge_err++;
      end
      if (c > 0 && m_mosi !== pmosi && !(!m_sck && psck)) glitch++;
      if (m_done) begin
        n_done++;
        done_cyc = c;
      end
      if (m_req) begin
        n_req++;
        wdata = (wi < wq.size()) ? wq[wi] : 8'($urandom);
        wi++;
      end
      if (m_rv) begin
        if (!rwv || rd_cnt >= neff || m_rdata !== rq[rd_cnt] ||
            c != (2 * (23 + 8 * rd_cnt) + 1) * d + 1) rd_err++;
        rd_cnt++;
      end
      miso = (falls < nb) ? sb[falls] : 1'b0;
      if (poke) start = (c == 10 || c == done_exp);
      if (n_done > 0 && c == done_cyc + 1) begin
        cs_after = m_cs;
        break;
      end
      if (c > done_exp + 4 * d + 10) begin
        timeout = 1;
        break;
      end
      psck = m_sck;
      pmosi = m_mosi;
      c++;
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    sel = 1'b0; rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (m_cs !== 1'b1) begin errors++; $display("FAIL rst_cs: got %b want 1", m_cs); end
    checks++; if (m_sck !== 1'b0) begin errors++; $display("FAIL rst_sck: got %b want 0", m_sck); end
    checks++; if (m_mosi !== 1'b0) begin errors++; $display("FAIL rst_mosi: got %b want 0", m_mosi); end
    checks++; if ({m_busy, m_done, m_req, m_rv} !== 4'b0000) begin errors++; $display("FAIL rst_flags: got %b want 0000", {m_busy, m_done, m_req, m_rv}); end
    checks++; if (m_rdata !== 8'h00) begin errors++; $display("FAIL rst_rdata: got %h want 00", m_rdata); end
    wq = '{8'h5A, 8'h00};
    rst_n = 1'b1;
    run_txn(2, 1'b0, 8'h31, 8'd1, 1'b0);
    checks++; if (cs_t0 !== 1'b0) begin errors++; $display("FAIL first_edge_start: cs at t0 got %b want 0", cs_t0); end
    checks++; if (n_done !== 1) begin errors++; $display("FAIL first_txn_done: got %0d want 1", n_done); end
    checks++; if (mosi_err !== 0) begin errors++; $display("FAIL first_txn_mosi: got %0d bad bits (first %0d) want 0", mosi_err, first_bad); end
  endtask

  task automatic test_write();
    wq = '{8'h99, 8'h9A, 8'h9B, 8'h00};
    run_txn(2, 1'b0, 8'hFD, 8'd3, 1'b0);
    checks++; if (timeout) begin errors++; $display("FAIL wr_timeout: got no done want done"); end
    checks++; if (n_rise !== 40) begin errors++; $display("FAIL wr_rises: got %0d want 40", n_rise); end
    checks++; if (cs_low !== 162) begin errors++; $display("FAIL wr_cs_low: got %0d want 162", cs_low); end
    checks++; if (n_done !== 1 || done_cyc !== 162) begin errors++; $display("FAIL wr_done: got %0d at %0d want 1 at 162", n_done, done_cyc); end
    checks++; if (mosi_err !== 0) begin errors++; $display("FAIL wr_mosi: got %0d bad bits (first %0d) want 0", mosi_err, first_bad); end
    checks++; if (edge_err !== 0) begin errors++; $display("FAIL wr_sck_timing: got %0d bad edges want 0", edge_err); end
    checks++; if (glitch !== 0) begin errors++; $display("FAIL wr_mosi_stable: got %0d changes off falling edge want 0", glitch); end
    checks++; if (n_req !== 3) begin errors++; $display("FAIL wr_req: got %0d want 3", n_req); end
    checks++; if (rd_cnt !== 0) begin errors++; $display("FAIL wr_no_rdata: got %0d want 0", rd_cnt); end
  endtask

  task automatic test_read();
    wq = '{8'h00};
    rq = '{8'hAA, 8'h55};
    run_txn(2, 1'b1, 8'h00, 8'd2, 1'b0);
    checks++; if (n_rise !== 32) begin errors++; $display("FAIL rd_rises: got %0d want 32", n_rise); end
    checks++; if (mosi_err !== 0) begin errors++; $display("FAIL rd_mosi: got %0d bad bits (first %0d) want 0", mosi_err, first_bad); end
    checks++; if (rd_cnt !== 2) begin errors++; $display("FAIL rd_count: got %0d want 2", rd_cnt); end
    checks++; if (rd_err !== 0) begin errors++; $display("FAIL rd_data: got %0d bad bytes want 0", rd_err); end
    checks++; if (n_req !== 0) begin errors++; $display("FAIL rd_no_req: got %0d want 0", n_req); end
    checks++; if (n_done !== 1) begin errors++; $display("FAIL rd_done: got %0d want 1", n_done); end
  endtask

  task automatic test_len_zero();
    wq = '{8'($urandom), 8'($urandom)};
    run_txn(2, 1'b0, 8'($urandom), 8'd0, 1'b0);
    checks++; if (n_rise !== 24) begin errors++; $display("FAIL len0_rises: got %0d want 24", n_rise); end
    checks++; if (cs_low !== 49 * 2) begin errors++; $display("FAIL len0_cs_low: got %0d want %0d", cs_low, 49 * 2); end
    checks++; if (n_req !== 1) begin errors++; $display("FAIL len0_req: got %0d want 1", n_req); end
    checks++; if (mosi_err !== 0) begin errors++; $display("FAIL len0_mosi: got %0d bad bits want 0", mosi_err); end
  endtask

  task automatic test_random();
    logic rwv;
    logic [7:0] av, lv;
    int nb;
    for (int i = 0; i < 6; i++) begin
      rwv = 1'($urandom);
      av = 8'($urandom);
      lv = 8'($urandom_range(1, 5));
      nb = 8 * (2 + int'(lv));
      wq = {};
      rq = {};
      for (int j = 0; j <= int'(lv); j++) begin
        wq.push_back(8'($urandom));
        rq.push_back(8'($urandom));
      end
      run_txn(2, rwv, av, lv, 1'b0);
      checks++; if (n_rise !== nb) begin errors++; $display("FAIL rnd%0d_rises: got %0d want %0d", i, n_rise, nb); end
      checks++; if (done_cyc !== (2 * nb + 1) * 2 || n_done !== 1) begin errors++; $display("FAIL rnd%0d_done: got %0d at %0d want 1 at %0d", i, n_done, done_cyc, (2 * nb + 1) * 2); end
      checks++; if (mosi_err !== 0) begin errors++; $display("FAIL rnd%0d_mosi: got %0d bad bits (first %0d) want 0", i, mosi_err, first_bad); end
      checks++; if (n_req !== (rwv ? 0 : int'(lv))) begin errors++; $display("FAIL rnd%0d_req: got %0d want %0d", i, n_req, rwv ? 0 : int'(lv)); end
      checks++; if (rd_cnt !== (rwv ? int'(lv) : 0) || rd_err !== 0) begin errors++; $display("FAIL rnd%0d_rdata: got %0d pulses %0d bad want %0d pulses 0 bad", i, rd_cnt, rd_err, rwv ? int'(lv) : 0); end
    end
  endtask

  task automatic test_back_to_back();
    wq = '{8'hC3, 8'h00};
    run_txn(2, 1'b0, 8'h42, 8'd1, 1'b1);
    checks++; if (mosi_err !== 0 || n_done !== 1) begin errors++; $display("FAIL busy_start_ignored: got %0d bad bits %0d done want 0 and 1", mosi_err, n_done); end
    checks++; if (cs_after !== 1'b1) begin errors++; $display("FAIL done_cycle_start_ignored: cs after done got %b want 1", cs_after); end
    rq = '{8'h6E};
    run_txn(2, 1'b1, 8'h17, 8'd1, 1'b0);
    checks++; if (cs_t0 !== 1'b0) begin errors++; $display("FAIL start_after_done: cs at t0 got %b want 0", cs_t0); end
    checks++; if (mosi_err !== 0 || rd_err !== 0 || rd_cnt !== 1) begin errors++; $display("FAIL b2b_read: got %0d bad bits %0d bad bytes %0d pulses want 0 0 1", mosi_err, rd_err, rd_cnt); end
  endtask

  task automatic test_reset_mid();
    int late_done;
    sel = 1'b0;
    start = 1'b1; rw = 1'b0; addr = 8'hFF; len = 8'd2; wdata = 8'h11;
    @(negedge clk);
    start = 1'b0;
    repeat (47) @(negedge clk);
    checks++; if (m_busy !== 1'b1 || m_sck !== 1'b1 || m_mosi !== 1'b1) begin errors++; $display("FAIL mid_pre_reset: busy/sck/mosi got %b%b%b want 111", m_busy, m_sck, m_mosi); end
    rst_n = 1'b0;
    #1;
    checks++; if ({m_cs, m_sck, m_mosi, m_busy} !== 4'b1000) begin errors++; $display("FAIL mid_reset_async: cs/sck/mosi/busy got %b want 1000", {m_cs, m_sck, m_mosi, m_busy}); end
    late_done = 0;
    repeat (3) begin
      @(negedge clk);
      if (m_done) late_done++;
    end
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (m_done || !m_cs) late_done++;
    end
    checks++; if (late_done !== 0) begin errors++; $display("FAIL mid_reset_no_done: got %0d stray cycles want 0", late_done); end
    wq = '{8'hE7, 8'h18, 8'h00};
    run_txn(2, 1'b0, 8'h5C, 8'd2, 1'b0);
    checks++; if (mosi_err !== 0 || n_rise !== 32 || n_done !== 1) begin errors++; $display("FAIL post_reset_write: got %0d bad bits %0d rises %0d done want 0 32 1", mosi_err, n_rise, n_done); end
  endtask

  task automatic test_clkdiv5();
    sel = 1'b1;
    wq = '{8'($urandom), 8'($urandom), 8'($urandom)};
    run_txn(5, 1'b0, 8'($urandom), 8'd2, 1'b0);
    checks++; if (edge_err !== 0 || n_rise !== 32) begin errors++; $display("FAIL div5_wr_timing: got %0d bad edges %0d rises want 0 32", edge_err, n_rise); end
    checks++; if (cs_low !== 65 * 5) begin errors++; $display("FAIL div5_cs_low: got %0d want %0d", cs_low, 65 * 5); end
    checks++; if (mosi_err !== 0 || glitch !== 0) begin errors++; $display("FAIL div5_wr_mosi: got %0d bad bits %0d unstable want 0 0", mosi_err, glitch); end
    rq = '{8'($urandom), 8'($urandom)};
    run_txn(5, 1'b1, 8'($urandom), 8'd1, 1'b0);
    checks++; if (edge_err !== 0 || rd_err !== 0 || rd_cnt !== 1) begin errors++; $display("FAIL div5_read: got %0d bad edges %0d bad bytes %0d pulses want 0 0 1", edge_err, rd_err, rd_cnt); end
    sel = 1'b0;
  endtask

  initial begin
    errors = 0; checks = 0;
    rst_n = 1'b0; start = 1'b0; sel = 1'b0; rw = 1'b0;
    addr = '0; len = '0; wdata = '0; miso = 1'b0;
    @(negedge clk);
    test_reset();
    test_write();
    test_read();
    test_len_zero();
    test_random();
    test_back_to_back();
    test_reset_mid();
    test_clkdiv5();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
